// File: rtl/clock_display_scan.sv
// clock_display_scan: multiplexed HH:MM seven-segment driver.
// Snapshots hours/minutes/alarm once per scan frame, blinks while the alarm
// is active and shows dashes for out-of-range fields. All outputs registered
// and computed from next state so they change with digit_idx.
module clock_display_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [4:0] hours,
  input  logic [5:0] minutes,
  input  logic       alarm,
  output logic [6:0] seg,
  output logic [3:0] dig,
  output logic       colon
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [6:0]    SEG_DASH   = 7'h40;

  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    digit_idx_q, digit_idx_d;
  logic [4:0]    snap_h_q, snap_h_d;
  logic [5:0]    snap_m_q, snap_m_d;
  logic          snap_a_q, snap_a_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_ph_q, blink_ph_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    dig_q, dig_d;
  logic          colon_q, colon_d;

  logic          digit_wrap;
  logic          frame_edge;
  logic [3:0]    h_tens, h_units, m_tens, m_units;
  logic          h_ok, m_ok;

  function automatic logic [6:0] seg_code(input logic [3:0] v);
    case (v)
      4'd0:    seg_code = 7'h3F;
      4'd1:    seg_code = 7'h06;
      4'd2:    seg_code = 7'h5B;
      4'd3:    seg_code = 7'h4F;
      4'd4:    seg_code = 7'h66;
      4'd5:    seg_code = 7'h6D;
      4'd6:    seg_code = 7'h7D;
      4'd7:    seg_code = 7'h07;
      4'd8:    seg_code = 7'h7F;
      4'd9:    seg_code = 7'h6F;
      default: seg_code = 7'h00;
    endcase
  endfunction

  // Next-state for scan/frame/blink counters and snapshots, plus registered outputs from that next state.
  always_comb begin
    scan_cnt_d  = scan_cnt_q;
    digit_idx_d = digit_idx_q;
    snap_h_d    = snap_h_q;
    snap_m_d    = snap_m_q;
    snap_a_d    = snap_a_q;
    frame_cnt_d = frame_cnt_q;
    blink_ph_d  = blink_ph_q;
    seg_d       = 7'h00;
    dig_d       = 4'b0000;
    colon_d     = 1'b0;
    digit_wrap  = (scan_cnt_q == SCAN_LAST);
    frame_edge  = digit_wrap && (digit_idx_q == 2'd0);

    if (ena) begin
      if (digit_wrap) begin
        scan_cnt_d  = '0;
        digit_idx_d = digit_idx_q - 2'd1;
      end else begin
        scan_cnt_d = scan_cnt_q + SW'(1);
      end
      if (frame_edge) begin
        snap_h_d = hours;
        snap_m_d = minutes;
        snap_a_d = alarm;
        if (frame_cnt_q == FRAME_LAST) begin
          frame_cnt_d = '0;
          blink_ph_d  = ~blink_ph_q;
        end else begin
          frame_cnt_d = frame_cnt_q + FW'(1);
        end
      end
    end

    h_ok    = (snap_h_d <= 5'd23);
    m_ok    = (snap_m_d <= 6'd59);
    h_tens  = 4'(snap_h_d / 5'd10);
    h_units = 4'(snap_h_d % 5'd10);
    m_tens  = 4'(snap_m_d / 6'd10);
    m_units = 4'(snap_m_d % 6'd10);

    if (ena) begin
      colon_d = ~blink_ph_d;
      if (!(snap_a_d && blink_ph_d)) begin
        dig_d = 4'b0001 << digit_idx_d;
        case (digit_idx_d)
          2'd3:    seg_d = h_ok ? seg_code(h_tens)  : SEG_DASH;
          2'd2:    seg_d = h_ok ? seg_code(h_units) : SEG_DASH;
          2'd1:    seg_d = m_ok ? seg_code(m_tens)  : SEG_DASH;
          default: seg_d = m_ok ? seg_code(m_units) : SEG_DASH;
        endcase
      end
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      scan_cnt_q  <= '0;
      digit_idx_q <= 2'd3;
      snap_h_q    <= '0;
      snap_m_q    <= '0;
      snap_a_q    <= 1'b0;
      frame_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      seg_q       <= '0;
      dig_q       <= '0;
      colon_q     <= 1'b0;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      snap_h_q    <= snap_h_d;
      snap_m_q    <= snap_m_d;
      snap_a_q    <= snap_a_d;
      frame_cnt_q <= frame_cnt_d;
      blink_ph_q  <= blink_ph_d;
      seg_q       <= seg_d;
      dig_q       <= dig_d;
      colon_q     <= colon_d;
    end
  end

  assign seg   = seg_q;
  assign dig   = dig_q;
  assign colon = colon_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Testbench for clock_display_scan: table of display vectors, hand-written
// corner sequences and randomized stimulus, all against a model that works
// from a count of enabled cycles since reset.
module tb_clock_display_scan;

  localparam int SD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic       alarm;
  logic [6:0] seg;
  logic [3:0] dig;
  logic       colon;

  clock_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .hours(hours), .minutes(minutes),
    .alarm(alarm), .seg(seg), .dig(dig), .colon(colon)
  );

  // free-running clock
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // model state: enabled cycles since reset and the captured snapshot
  int         n;
  int         m_h;
  int         m_m;
  logic       m_a;
  logic [6:0] exp_seg;
  logic [3:0] exp_dig;
  logic       exp_colon;
  int         cur_digit;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  typedef struct {
    int         h;
    int         m;
    logic [6:0] s3, s2, s1, s0;
  } vec_t;

  vec_t table_v [8];

  function automatic logic [6:0] digit_seg(int d, int h, int m);
    if (d >= 2) begin
      if (h > 23) return 7'h40;
      return (d == 3) ? seg_tab[h / 10] : seg_tab[h % 10];
    end
    if (m > 59) return 7'h40;
    return (d == 1) ? seg_tab[m / 10] : seg_tab[m % 10];
  endfunction

  // advance the model by one clock edge with the inputs currently driven
  task automatic model_edge();
    int frame;
    logic blink;
    exp_seg = 7'h00;
    exp_dig = 4'h0;
    exp_colon = 1'b0;
    if (rst_n) begin
      n = 0; m_h = 0; m_m = 0; m_a = 1'b0;
    end else if (ena) begin
      n++;
      if (n % FRAME == 0) begin
        m_h = int'(hours); m_m = int'(minutes); m_a = alarm;
      end
      frame = n / FRAME;
      blink = ((frame / BF) % 2) == 1;
      cur_digit = 3 - ((n / SD) % 4);
      exp_colon = ~blink;
      if (!(m_a && blink)) begin
        exp_dig = 4'b0001 << cur_digit;
        exp_seg = digit_seg(cur_digit, m_h, m_m);
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s at n=%0d: got {seg,dig,colon}=%h, expected %h", name, n, act, req);
    end
  endtask

  task automatic applyStimulus(input string name);
    @(posedge clk);
    model_edge();
    #1;
    checkOutput(name, {seg, dig, colon}, {exp_seg, exp_dig, exp_colon});
  endtask

  task automatic run(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(name);
  endtask

  // step until the model reaches the given phase within the period, bounded
  task automatic run_until(input string name, input int period, input int phase);
    int guard = 0;
    while ((n % period) != phase && guard < 200) begin
      applyStimulus(name);
      guard++;
    end
    if (guard >= 200) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: phase %0d not reached, got n=%0d", name, phase, n);
    end
  endtask

  initial begin
    table_v[0] = '{13, 47, 7'h06, 7'h4F, 7'h66, 7'h07};
    table_v[1] = '{24, 60, 7'h40, 7'h40, 7'h40, 7'h40};
    table_v[2] = '{23, 60, 7'h5B, 7'h4F, 7'h40, 7'h40};
    table_v[3] = '{ 5,  7, 7'h3F, 7'h6D, 7'h3F, 7'h07};
    table_v[4] = '{ 0,  0, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    table_v[5] = '{31, 63, 7'h40, 7'h40, 7'h40, 7'h40};
    table_v[6] = '{ 9, 59, 7'h3F, 7'h6F, 7'h6D, 7'h6F};
    table_v[7] = '{20, 10, 7'h5B, 7'h3F, 7'h06, 7'h3F};

    rst_n = 1'b1; ena = 1'b0; hours = 5'd0; minutes = 6'd0; alarm = 1'b0;
    n = 0; m_h = 0; m_m = 0; m_a = 1'b0; cur_digit = 3;
    run("reset", 2);

    // bring-up: first frame shows 00:00, next frame shows 13:47
    rst_n = 1'b0; ena = 1'b1; hours = 5'd13; minutes = 6'd47;
    applyStimulus("first_edge");
    checkOutput("first_edge_const", {seg, dig, colon}, {7'h3F, 4'b1000, 1'b1});
    run("bringup", 31);

    // minutes change mid-frame only lands at the next boundary
    run_until("midframe_align", FRAME, 6);
    minutes = 6'd48;
    run("midframe", 30);

    // table vectors: captured at a boundary, checked over the following frame
    for (int t = 0; t < 8; t++) begin
      hours = 5'(table_v[t].h);
      minutes = 6'(table_v[t].m);
      run_until("table_align", FRAME, FRAME - 1);
      for (int c = 0; c < FRAME; c++) begin
        applyStimulus("table_model");
        case (cur_digit)
          3: checkOutput("table_h10", {5'd0, seg}, {5'd0, table_v[t].s3});
          2: checkOutput("table_h1",  {5'd0, seg}, {5'd0, table_v[t].s2});
          1: checkOutput("table_m10", {5'd0, seg}, {5'd0, table_v[t].s1});
          default: checkOutput("table_m1", {5'd0, seg}, {5'd0, table_v[t].s0});
        endcase
      end
    end

    // alarm blinking for several blink periods, then released
    hours = 5'd7; minutes = 6'd30; alarm = 1'b1;
    run("alarm_on", 6 * FRAME);
    alarm = 1'b0;
    run("alarm_off", 3 * FRAME);

    // enable dropped mid-digit for 10 cycles
    run_until("ena_align", SD, 2);
    ena = 1'b0;
    run("ena_low", 10);
    ena = 1'b1;
    run("ena_resume", 20);

    // reset asserted while digit_idx is 1
    run_until("rst_align", FRAME, 2 * SD + 1);
    rst_n = 1'b1;
    applyStimulus("rst_mid");
    checkOutput("rst_mid_const", {seg, dig, colon}, 12'h000);
    rst_n = 1'b0;
    applyStimulus("rst_release");
    checkOutput("rst_release_const", {seg, dig, colon}, {7'h3F, 4'b1000, 1'b1});
    run("rst_after", 20);

    // randomized stimulus
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) hours = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 4) == 0) minutes = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 39) == 0) alarm = ~alarm;
      ena = ($urandom_range(0, 9) != 0);
      rst_n = ($urandom_range(0, 199) == 0);
      applyStimulus("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
